// File: rtl/led_request_arbiter.sv
// Button front end for the RGB LED: synchronise, debounce and edge-detect two buttons,
// latch presses as pending requests, and serve them round-robin as timed colour windows.
`timescale 1ns/1ps
module led_request_arbiter #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 67108864,
  parameter int unsigned GAP_CYCLES      = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERV1 = 2'd1,
    SERV2 = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Bit 0 is btn1, bit 1 is btn2 throughout.
  logic [1:0]            btn_meta;
  logic [1:0]            btn_sync;
  logic [1:0]            db;
  logic [1:0]            db_d;
  logic [1:0]            press;
  logic [1:0][CNT_W-1:0] db_cnt;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [1:0]       pend;
  logic [1:0]       pend_nxt;
  logic             last_b2;
  logic             last_b2_nxt;
  logic [1:0]       pick;
  logic [1:0]       serv_mask;
  logic             take;
  logic [2:0]       led_nxt;
  logic [1:0]       grant_nxt;
  logic             busy_nxt;

  // Input conditioning: 2-FF sync, level debounce, registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      db       <= '0;
      db_d     <= '0;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= {btn2, btn1};
      btn_sync <= btn_meta;
      db_d     <= db;
      press    <= db & ~db_d;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Service FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      pend    <= '0;
      last_b2 <= 1'b1;
      led_r   <= 1'b0;
      led_g   <= 1'b0;
      led_b   <= 1'b1;
      grant   <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pend    <= pend_nxt;
      last_b2 <= last_b2_nxt;
      {led_r, led_g, led_b} <= led_nxt;
      grant   <= grant_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next state, timer, pending flags and output decode.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    pend_nxt    = pend;
    last_b2_nxt = last_b2;
    take        = 1'b0;
    serv_mask   = 2'b00;
    led_nxt     = 3'b001;
    grant_nxt   = 2'b00;
    busy_nxt    = 1'b0;

    // Round-robin: on a tie the source not granted last time wins.
    if (pend == 2'b11) begin
      pick = last_b2 ? 2'b01 : 2'b10;
    end else begin
      pick = pend;
    end

    case (state)
      IDLE: begin
        take = (pick != 2'b00);
      end
      SERV1, SERV2: begin
        serv_mask = (state == SERV1) ? 2'b01 : 2'b10;
        if ((press & serv_mask) != 2'b00) begin
          timer_nxt = '0;
        end else if (timer == HOLD_LAST) begin
          state_nxt = GAP;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          take      = (pick != 2'b00);
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    if (take) begin
      state_nxt   = pick[0] ? SERV1 : SERV2;
      timer_nxt   = '0;
      last_b2_nxt = pick[1];
      pend_nxt    = pend & ~pick;
    end

    // Set after clear so a coinciding press wins; the source in service retriggers instead.
    pend_nxt = pend_nxt | (press & ~serv_mask);

    case (state_nxt)
      SERV1: begin
        led_nxt   = 3'b011;
        grant_nxt = 2'b01;
        busy_nxt  = 1'b1;
      end
      SERV2: begin
        led_nxt   = 3'b110;
        grant_nxt = 2'b10;
        busy_nxt  = 1'b1;
      end
      GAP: begin
        led_nxt   = 3'b000;
        grant_nxt = 2'b00;
        busy_nxt  = 1'b1;
      end
      default: begin
        led_nxt   = 3'b001;
        grant_nxt = 2'b00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_request_arbiter.sv
// Directed scoreboard bench for led_request_arbiter with short timing parameters.
`timescale 1ns/1ps
module tb_led_request_arbiter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DB    = 4;
  localparam int unsigned HOLD  = 20;
  localparam int unsigned GAPC  = 3;

  logic       clk;
  logic       rst_n;
  logic       btn1;
  logic       btn2;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic [1:0] grant;
  logic       busy;

  led_request_arbiter #(
    .CNT_W(CNT_W),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn1(btn1),
    .btn2(btn2),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b),
    .grant(grant),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [5:0] exp;
    int         tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c     = 0;

  // Expected {led_r,led_g,led_b,grant,busy} after clock edge number t.
  task automatic push(input int t, input logic [2:0] rgb, input logic [1:0] g,
                      input logic b, input int tag);
    exp_t e;
    e.t   = t;
    e.exp = {rgb, g, b};
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic compare(input int tag, input logic [5:0] e);
    logic [5:0] o;
    o = {led_r, led_g, led_b, grant, busy};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL step%0d cyc=%0d rgb_grant_busy observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].t <= cyc) begin
      e = sbq.pop_front();
      compare(e.tag, e.exp);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn1  = 1'b0;
    btn2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare(1, {3'b001, 2'b00, 1'b0});
    rst_n = 1'b1;
    tick();
    tick();

    // Tie from reset: btn1 first (last_grant resets to btn2), then btn2.
    c = cyc;
    btn1 = 1'b1;
    btn2 = 1'b1;
    push(c + 8,  3'b001, 2'b00, 1'b0, 20);
    push(c + 9,  3'b011, 2'b01, 1'b1, 21);
    push(c + 28, 3'b011, 2'b01, 1'b1, 22);
    push(c + 29, 3'b000, 2'b00, 1'b1, 23);
    push(c + 31, 3'b000, 2'b00, 1'b1, 24);
    push(c + 32, 3'b110, 2'b10, 1'b1, 25);
    push(c + 51, 3'b110, 2'b10, 1'b1, 26);
    push(c + 52, 3'b000, 2'b00, 1'b1, 27);
    push(c + 55, 3'b001, 2'b00, 1'b0, 28);
    run_to(c + 12);
    btn1 = 1'b0;
    btn2 = 1'b0;
    run_to(c + 60);

    // Repeat tie: btn1 first again; then async reset in the middle of SERV2.
    c = cyc;
    btn1 = 1'b1;
    btn2 = 1'b1;
    push(c + 9,  3'b011, 2'b01, 1'b1, 30);
    push(c + 32, 3'b110, 2'b10, 1'b1, 31);
    push(c + 40, 3'b110, 2'b10, 1'b1, 32);
    run_to(c + 12);
    btn1 = 1'b0;
    btn2 = 1'b0;
    run_to(c + 40);
    #2 rst_n = 1'b0;
    #1 compare(40, {3'b001, 2'b00, 1'b0});
    #2 rst_n = 1'b1;
    tick();
    tick();

    // Single clean btn1 press.
    c = cyc;
    btn1 = 1'b1;
    push(c + 8,  3'b001, 2'b00, 1'b0, 50);
    push(c + 9,  3'b011, 2'b01, 1'b1, 51);
    push(c + 28, 3'b011, 2'b01, 1'b1, 52);
    push(c + 29, 3'b000, 2'b00, 1'b1, 53);
    push(c + 31, 3'b000, 2'b00, 1'b1, 54);
    push(c + 32, 3'b001, 2'b00, 1'b0, 55);
    run_to(c + 12);
    btn1 = 1'b0;
    run_to(c + 40);

    // Glitch of 3 cycles, shorter than the debounce window.
    c = cyc;
    btn1 = 1'b1;
    push(c + 10, 3'b001, 2'b00, 1'b0, 60);
    push(c + 20, 3'b001, 2'b00, 1'b0, 61);
    run_to(c + 3);
    btn1 = 1'b0;
    run_to(c + 20);

    // Retrigger at timer 15: window restarts at edge c+25 and ends at c+45.
    c = cyc;
    btn1 = 1'b1;
    push(c + 9,  3'b011, 2'b01, 1'b1, 70);
    push(c + 29, 3'b011, 2'b01, 1'b1, 71);
    push(c + 44, 3'b011, 2'b01, 1'b1, 72);
    push(c + 45, 3'b000, 2'b00, 1'b1, 73);
    push(c + 48, 3'b001, 2'b00, 1'b0, 74);
    push(c + 60, 3'b001, 2'b00, 1'b0, 75);
    run_to(c + 7);
    btn1 = 1'b0;
    run_to(c + 17);
    btn1 = 1'b1;
    run_to(c + 30);
    btn1 = 1'b0;
    run_to(c + 62);

    // Two btn2 presses during SERV1 collapse into one SERV2.
    c = cyc;
    btn1 = 1'b1;
    push(c + 9,  3'b011, 2'b01, 1'b1, 80);
    push(c + 31, 3'b000, 2'b00, 1'b1, 81);
    push(c + 32, 3'b110, 2'b10, 1'b1, 82);
    push(c + 52, 3'b000, 2'b00, 1'b1, 83);
    push(c + 55, 3'b001, 2'b00, 1'b0, 84);
    push(c + 62, 3'b001, 2'b00, 1'b0, 85);
    run_to(c + 2);
    btn2 = 1'b1;
    run_to(c + 8);
    btn1 = 1'b0;
    run_to(c + 9);
    btn2 = 1'b0;
    run_to(c + 15);
    btn2 = 1'b1;
    run_to(c + 23);
    btn2 = 1'b0;
    run_to(c + 65);

    // btn2 press landing in its own GAP is served right after that GAP.
    c = cyc;
    btn2 = 1'b1;
    push(c + 9,  3'b110, 2'b10, 1'b1, 90);
    push(c + 29, 3'b000, 2'b00, 1'b1, 91);
    push(c + 31, 3'b000, 2'b00, 1'b1, 92);
    push(c + 32, 3'b110, 2'b10, 1'b1, 93);
    push(c + 51, 3'b110, 2'b10, 1'b1, 94);
    push(c + 52, 3'b000, 2'b00, 1'b1, 95);
    push(c + 55, 3'b001, 2'b00, 1'b0, 96);
    run_to(c + 9);
    btn2 = 1'b0;
    run_to(c + 23);
    btn2 = 1'b1;
    run_to(c + 30);
    btn2 = 1'b0;
    run_to(c + 60);

    if (sbq.size() != 0) begin
      bad += sbq.size();
      total += sbq.size();
      $error("FAIL scoreboard left=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_request_arbiter.md
Name: led_request_arbiter

Overview:
- Front-end controller for the board's two push-buttons and single RGB LED.
- Synchronises and debounces `btn1`/`btn2`, and converts presses into pending service requests.
- Arbitrates the two requests round-robin and sequences timed LED colour windows, separated by a blanking gap.
- Replaces direct button-to-LED wiring in the top level; the LED is driven only from this block.

Parameters:
- CNT_W, 32, width of the debounce and service timers.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles required to accept a level change.
- HOLD_CYCLES, 67108864, cycles a granted colour stays lit.
- GAP_CYCLES, 2500000, cycles of LED-off blanking after each service window.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn1  input  1  raw button 1, asynchronous, active-high
- btn2  input  1  raw button 2, asynchronous, active-high
- led_r  output  1  red LED drive, registered
- led_g  output  1  green LED drive, registered
- led_b  output  1  blue LED drive, registered
- grant  output  2  one-hot source in service: 01 = btn1, 10 = btn2, 00 otherwise
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (`rst_n`), synchronous deassertion assumed at board level.
- Reset values (asynchronous, applied immediately, including mid-operation):
  - state = IDLE; led_r/g/b = 0/0/1; grant = 00; busy = 0.
  - Both pending flags = 0; synchroniser FFs = 0; debounced levels = 0; timers = 0; last_grant = btn2, so btn1 wins the first tie.
- Input conditioning, per button:
  - 2-FF synchroniser produces s.
  - Debounce counter clears on any cycle with s == db.
  - Counter increments on each cycle with s != db.
  - When s != db for DEBOUNCE_CYCLES consecutive cycles: db <= s and counter clears.
  - Registered rising-edge detect on db gives a 1-cycle press pulse. Releases generate nothing.
- A button held through reset release is accepted as one press after debounce.
- Pending flags:
  - A press pulse sets pend[x] on the next edge.
  - A grant of x clears pend[x]. If set and clear coincide, set wins.
  - A pulse while pend[x] is already set is absorbed (no counting).
- FSM states: IDLE, SERV1, SERV2, GAP.
  - IDLE: if any pend, grant on the next edge. Both pending → the source != last_grant. Otherwise the single pending source. Grant clears its pend, loads the timer with 0, and updates last_grant.
  - SERV1: leds 0/1/1, grant 01. Timer increments each cycle; at timer == HOLD_CYCLES-1 → GAP, timer <= 0. SERV1 therefore lasts exactly HOLD_CYCLES cycles.
  - SERV2: leds 1/1/0, grant 10. Same timing as SERV1.
  - GAP: leds 0/0/0, grant 00. Lasts GAP_CYCLES cycles. At the end, the same arbitration as IDLE picks SERV1/SERV2 directly; if nothing is pending → IDLE.
  - IDLE outputs: leds 0/0/1, grant 00.
- Retrigger: a press pulse from the source currently in SERVx restarts its timer to 0 (window extended) and does not set pend. A press from the other source sets its pend.
- A press during GAP sets pend and is served when GAP ends.
- Outputs are registered and decoded from the next state, so they change on the same edge as state.
- Latency, clean press from IDLE, counted from the first clk edge that samples `btn` high:
  - s high after 2 edges.
  - db high DEBOUNCE_CYCLES edges later.
  - Pulse +1, pend +1, SERVx/LED +1.
  - Total: LED changes at edge DEBOUNCE_CYCLES+5.
- Widths: timers are CNT_W bits unsigned, compared for equality only, and never wrap in normal operation.
- Parameters must satisfy 1 <= value < 2^CNT_W.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, GAP_CYCLES=3):
- Reset with buttons low → leds 0/0/1, grant 00, busy 0. Assert rst_n low mid-SERV2 → outputs return to 0/0/1 asynchronously, without waiting for clk.
- btn1 high from edge 0 → leds 0/1/1 and grant 01 at edge 9. Stay 20 cycles, then 0/0/0 for 3 cycles, then 0/0/1 and busy 0.
- btn1 glitch high for 3 cycles, then low → no pulse, LEDs stay 0/0/1.
- btn1 and btn2 pressed on the same edge → SERV1 (20 cycles), GAP (3), SERV2 (20), GAP (3), IDLE. A repeat tie then serves btn1 first again, since last_grant = btn2.
- In SERV1 at timer=15, a fresh btn1 press (release plus debounce) → window restarts and ends exactly 20 cycles after the pulse. No extra service follows.
- btn2 pressed twice during SERV1 → served once only after GAP (absorbed duplicate). Then a btn2 press during its own GAP → served after that GAP.
